// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer-type encodings, arbiter state and HMASTER width.
package ahb_pkg;

  localparam int unsigned HMASTER_W = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ARB_DEFAULT = 2'd0,
    ARB_OWNED   = 2'd1,
    ARB_LOCKED  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr, wrapping.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      idx = PW'((32'(ptr) + j) % N);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with lock support, per-tenure transfer budget and
// HREADY-gated address-phase handover (HMASTER/HMASTLOCK).
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_TENURE     = 16
) (
  input  logic                   clock,
  input  logic                   Rst,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [HMASTER_W-1:0]   HMASTER,
  output logic                   HMASTLOCK
);

  localparam int unsigned PW = $clog2(NUM_MASTERS);
  localparam int unsigned TW = $clog2(MAX_TENURE + 1);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t             state, state_nxt;
  logic [TW-1:0]          tenure, tenure_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [HMASTER_W-1:0]   hmaster_nxt;
  logic                   hmastlock_nxt;

  logic [PW-1:0]          owner;
  logic [PW-1:0]          ptr;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic                   pick_valid;
  logic                   own_req;
  logic                   own_lock;
  logic                   xfer;
  logic                   arbitrate;
  logic                   under_budget;

  // Index of the currently granted master.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) owner = PW'(i);
    end
  end

  assign ptr = PW'((32'(owner) + 32'd1) % NUM_MASTERS);

  // Only the other masters go to the picker; the owner is handled as lowest priority.
  rr_picker #(.N(NUM_MASTERS), .PW(PW)) u_picker (
    .req   (HBUSREQ & ~HGRANT),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_ff @(posedge clock) begin
    if (Rst) begin
      state     <= ARB_DEFAULT;
      HGRANT    <= DEF_GRANT;
      HMASTER   <= HMASTER_W'(DEFAULT_MASTER);
      HMASTLOCK <= 1'b0;
      tenure    <= '0;
    end else begin
      state     <= state_nxt;
      HGRANT    <= grant_nxt;
      HMASTER   <= hmaster_nxt;
      HMASTLOCK <= hmastlock_nxt;
      tenure    <= tenure_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = HGRANT;
    tenure_nxt    = tenure;
    hmaster_nxt   = HMASTER;
    hmastlock_nxt = HMASTLOCK;
    arbitrate     = 1'b0;
    own_req       = HBUSREQ[owner];
    own_lock      = HLOCK[owner];
    xfer          = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    under_budget  = tenure < TW'(MAX_TENURE);

    if (HREADY) begin
      hmaster_nxt   = HMASTER_W'(owner);
      hmastlock_nxt = own_lock;
    end

    if (HREADY && xfer && (state != ARB_DEFAULT) && under_budget) begin
      tenure_nxt = tenure + TW'(1);
    end

    case (state)
      ARB_DEFAULT: begin
        if (HREADY && (HTRANS != HTRANS_BUSY)) arbitrate = 1'b1;
      end
      ARB_OWNED: begin
        if (HREADY && own_lock) state_nxt = ARB_LOCKED;
        else if (HREADY && (HTRANS != HTRANS_BUSY)) arbitrate = 1'b1;
      end
      ARB_LOCKED: begin
        if (HREADY && !own_lock && (HTRANS == HTRANS_IDLE)) arbitrate = 1'b1;
      end
      default: state_nxt = ARB_DEFAULT;
    endcase

    // In ARB_DEFAULT nobody has a tenure to protect, so only the scan applies.
    if (arbitrate) begin
      if ((state != ARB_DEFAULT) && own_req && under_budget) begin
        state_nxt = ARB_OWNED;
      end else if (pick_valid) begin
        grant_nxt = pick_grant;
        state_nxt = ARB_OWNED;
      end else if (own_req) begin
        state_nxt = ARB_OWNED;
      end else begin
        grant_nxt = DEF_GRANT;
        state_nxt = ARB_DEFAULT;
      end
    end

    if ((grant_nxt != HGRANT) || (state_nxt == ARB_DEFAULT)) tenure_nxt = '0;
  end

endmodule
